rx_frame_filter: RTL

- Streaming receive-side stage that sits between mac_rx and the packet-buffer writer (mac_rx_ifc or its successor).
- Assembles the dibit stream into bytes and checks Ethernet CRC32.
- Strips the 4-byte FCS and applies the destination-address filter.
- Emits payload bytes with their buffer index, then one status pulse per frame, so the downstream stage raises its doorbell only for frames that passed every check.

---
 rtl/net_pkg.sv | 29 ++
 rtl/crc32_byte.sv | 21 ++
 rtl/rx_frame_filter.sv | 143 ++++++++++++++
 3 files changed

// File: rtl/net_pkg.sv
// Shared Ethernet constants, receive-filter state encoding and status bit positions.
// Imported by the receive filter and by the CRC helper reused on the transmit side.
package net_pkg;

    localparam int ETH_MTU = 1500;
    localparam int ETH_MIN = 64;
    localparam int ETH_MAX = ETH_MTU + 18;

    localparam logic [31:0] CRC_POLY    = 32'hEDB88320;
    localparam logic [31:0] CRC_RESIDUE = 32'hDEBB20E3;
    localparam logic [47:0] BCAST_MAC   = 48'hFFFF_FFFF_FFFF;
    localparam logic [47:0] DEFAULT_MAC = 48'hb827eba43073;

    typedef enum logic [1:0] {RESYNC, IDLE, RECV, DONE} rx_state_t;

    localparam int ST_CRC   = 0;
    localparam int ST_ADDR  = 1;
    localparam int ST_ALIGN = 2;
    localparam int ST_RUNT  = 3;
    localparam int ST_OVER  = 4;

    // Byte idx of a MAC address as it appears on the wire (idx 0 = MSB).
    function automatic logic [7:0] mac_byte(input logic [47:0] mac, input logic [2:0] idx);
        logic [47:0] sh;
        sh = mac >> (8 * (5 - int'(idx)));
        return sh[7:0];
    endfunction

endpackage

// File: rtl/crc32_byte.sv
// Combinational reflected CRC-32 step: next CRC register value after one byte.
// Shared by the receive FCS check and the transmit FCS generator.
module crc32_byte
    import net_pkg::*;
(
    input  logic [31:0] crc_in,
    input  logic [7:0]  data,
    output logic [31:0] crc_out
);

    always_comb begin
        logic [31:0] c;
        // NOTE: blocking assignments here chain the eight bit-steps within one evaluation.
        c = crc_in ^ {24'h0, data};
        for (int i = 0; i < 8; i++) begin
            c = c[0] ? ((c >> 1) ^ CRC_POLY) : (c >> 1);
        end
        crc_out = c;
    end

endmodule

// File: rtl/rx_frame_filter.sv
// Receive-side frame filter: dibit-to-byte assembly, CRC-32 check, FCS stripping
// and destination-address filtering, with one status pulse per frame.
module rx_frame_filter
    import net_pkg::*;
#(
    parameter logic [47:0] MY_MAC  = DEFAULT_MAC,
    parameter bit          PROMISC = 1'b0,
    parameter int          MIN_LEN = ETH_MIN,
    parameter int          MAX_LEN = ETH_MAX
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        rx_valid,
    input  logic [1:0]  rx_data,
    output logic        out_valid,
    output logic [7:0]  out_data,
    output logic [10:0] out_index,
    output logic        done,
    output logic        done_ok,
    output logic [4:0]  done_status,
    output logic [10:0] done_len
);

    rx_state_t   state, state_nxt;
    logic [7:0]  shreg;
    logic [1:0]  dcnt;
    logic [31:0] crc, crc_nxt;
    logic [10:0] byte_cnt, cnt_inc;
    logic [7:0]  dl [4];
    logic [2:0]  dl_cnt;
    logic        uc_miss, bc_miss, oversize;
    logic        fresh, accept, byte_done;
    logic [7:0]  base_sh, new_byte;
    logic [1:0]  base_dcnt;
    logic [4:0]  status;

    // Outside RECV every accepted dibit starts a new frame from cleared state.
    assign fresh     = (state != RECV);
    assign accept    = rx_valid && (state != RESYNC);
    assign base_sh   = fresh ? 8'h00 : shreg;
    assign base_dcnt = fresh ? 2'd0 : dcnt;
    assign new_byte  = {rx_data, base_sh[7:2]};
    assign byte_done = accept && (base_dcnt == 2'd3);
    assign cnt_inc   = (byte_cnt == 11'h7FF) ? byte_cnt : byte_cnt + 11'd1;

    crc32_byte u_crc (
        .crc_in  (crc),
        .data    (new_byte),
        .crc_out (crc_nxt)
    );

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) state <= RESYNC;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            RESYNC:  if (!rx_valid) state_nxt = IDLE;
            IDLE:    if (rx_valid)  state_nxt = RECV;
            RECV:    if (!rx_valid) state_nxt = DONE;
            DONE:    state_nxt = rx_valid ? RECV : IDLE;
            default: state_nxt = RESYNC;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            shreg     <= '0;
            dcnt      <= '0;
            crc       <= '1;
            byte_cnt  <= '0;
            dl_cnt    <= '0;
            uc_miss   <= 1'b0;
            bc_miss   <= 1'b0;
            oversize  <= 1'b0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_index <= '0;
            // NOTE: the delay line is four flops, not a RAM, so resetting it is cheap and keeps out_data clean.
            for (int i = 0; i < 4; i++) dl[i] <= '0;
        end else begin
            out_valid <= 1'b0;
            if (fresh) begin
                shreg    <= '0;
                dcnt     <= '0;
                crc      <= '1;
                byte_cnt <= '0;
                dl_cnt   <= '0;
                uc_miss  <= 1'b0;
                bc_miss  <= 1'b0;
                oversize <= 1'b0;
            end
            if (accept) begin
                shreg <= new_byte;
                dcnt  <= base_dcnt + 2'd1;
            end
            if (byte_done) begin
                crc      <= crc_nxt;
                byte_cnt <= cnt_inc;
                dl[0]    <= dl[1];
                dl[1]    <= dl[2];
                dl[2]    <= dl[3];
                dl[3]    <= new_byte;
                if (dl_cnt != 3'd4) dl_cnt <= dl_cnt + 3'd1;
                if (byte_cnt < 11'd6) begin
                    if (new_byte != mac_byte(MY_MAC, byte_cnt[2:0]))    uc_miss <= 1'b1;
                    if (new_byte != mac_byte(BCAST_MAC, byte_cnt[2:0])) bc_miss <= 1'b1;
                end
                // The four newest bytes may be FCS, so only the oldest is released.
                if (cnt_inc > 11'(MAX_LEN)) begin
                    oversize <= 1'b1;
                end else if (dl_cnt == 3'd4) begin
                    out_valid <= 1'b1;
                    out_data  <= dl[0];
                    out_index <= byte_cnt - 11'd4;
                end
            end
        end
    end

    always_comb begin
        // NOTE: every output gets a default first so no path through this block infers a latch.
        status       = '0;
        done         = 1'b0;
        done_ok      = 1'b0;
        done_status  = '0;
        done_len     = '0;
        status[ST_CRC]   = (crc != CRC_RESIDUE);
        status[ST_ADDR]  = uc_miss && bc_miss && !PROMISC;
        status[ST_ALIGN] = (dcnt != 2'd0);
        status[ST_RUNT]  = (byte_cnt < 11'(MIN_LEN));
        status[ST_OVER]  = oversize;
        if (state == DONE) begin
            done        = 1'b1;
            done_status = status;
            done_ok     = ~|status;
            done_len    = (byte_cnt < 11'd4) ? 11'd0 : byte_cnt - 11'd4;
        end
    end

endmodule
